// File: rtl/key_bounce_gen.sv
// Push-button stimulus generator: emits clean or bouncy active-low presses on key_n
// and counts the falling edges and completed presses it produced.
module key_bounce_gen #(
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned BOUNCE_CYC = 100_000,
  parameter int unsigned HOLD_CYC   = 1_250_000,
  parameter int unsigned GAP_CYC    = 1_250_000,
  parameter int unsigned N_BOUNCE   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  n_press,
  input  logic        bounce_en,
  input  logic        clr_cnt,
  output logic        key_n,
  output logic        busy,
  output logic        done,
  output logic [7:0]  press_count,
  output logic [15:0] edge_count
);

  localparam int unsigned BC_W = (N_BOUNCE > 1) ? $clog2(N_BOUNCE) : 1;

  localparam logic [CNT_W-1:0] B_LOAD  = CNT_W'(BOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] H_LOAD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] G_LOAD  = CNT_W'(GAP_CYC - 1);
  localparam logic [BC_W-1:0]  BC_LAST = BC_W'(N_BOUNCE - 1);

  typedef enum logic [2:0] {
    IDLE,
    B_LOW,
    B_HIGH,
    HOLD,
    GAP
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic              key_n_q, key_n_d;
  logic              done_q, done_d;
  logic [3:0]        presses_q, presses_d;
  logic              bounce_q, bounce_d;
  logic [BC_W-1:0]   bcnt_q, bcnt_d;
  logic [7:0]        press_cnt_q;
  logic [15:0]       edge_cnt_q;
  logic              press_inc;
  logic              edge_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      key_n_q   <= 1'b1;
      done_q    <= 1'b0;
      presses_q <= '0;
      bounce_q  <= 1'b0;
      bcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      key_n_q   <= key_n_d;
      done_q    <= done_d;
      presses_q <= presses_d;
      bounce_q  <= bounce_d;
      bcnt_q    <= bcnt_d;
    end
  end

  // Every transition loads the next phase's (length - 1) so a phase lasts exactly
  // its programmed count and the new level appears on the same edge as the change.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    key_n_d   = key_n_q;
    done_d    = 1'b0;
    presses_d = presses_q;
    bounce_d  = bounce_q;
    bcnt_d    = bcnt_q;
    press_inc = 1'b0;
    edge_inc  = 1'b0;

    case (state_q)
      IDLE: begin
        key_n_d = 1'b1;
        if (start) begin
          if (n_press != 4'd0) begin
            presses_d = n_press;
            bounce_d  = bounce_en;
            bcnt_d    = '0;
            key_n_d   = 1'b0;
            edge_inc  = 1'b1;
            if (bounce_en) begin
              state_d = B_LOW;
              timer_d = B_LOAD;
            end else begin
              state_d = HOLD;
              timer_d = H_LOAD;
            end
          end else begin
            done_d = 1'b1;
          end
        end
      end

      B_LOW: begin
        if (timer_q == '0) begin
          state_d = B_HIGH;
          timer_d = B_LOAD;
          key_n_d = 1'b1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      B_HIGH: begin
        if (timer_q == '0) begin
          key_n_d  = 1'b0;
          edge_inc = 1'b1;
          if (bcnt_q == BC_LAST) begin
            state_d = HOLD;
            timer_d = H_LOAD;
          end else begin
            state_d = B_LOW;
            timer_d = B_LOAD;
            bcnt_d  = bcnt_q + BC_W'(1);
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      HOLD: begin
        if (timer_q == '0) begin
          state_d = GAP;
          timer_d = G_LOAD;
          key_n_d = 1'b1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      GAP: begin
        if (timer_q == '0) begin
          press_inc = 1'b1;
          if (presses_q == 4'd1) begin
            state_d   = IDLE;
            presses_d = '0;
            done_d    = 1'b1;
          end else begin
            presses_d = presses_q - 4'd1;
            bcnt_d    = '0;
            key_n_d   = 1'b0;
            edge_inc  = 1'b1;
            if (bounce_q) begin
              state_d = B_LOW;
              timer_d = B_LOAD;
            end else begin
              state_d = HOLD;
              timer_d = H_LOAD;
            end
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        key_n_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_cnt_q <= '0;
      edge_cnt_q  <= '0;
    end else if (clr_cnt) begin
      press_cnt_q <= '0;
      edge_cnt_q  <= '0;
    end else begin
      if (press_inc) press_cnt_q <= press_cnt_q + 8'd1;
      if (edge_inc)  edge_cnt_q  <= edge_cnt_q + 16'd1;
    end
  end

  assign key_n       = key_n_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign press_count = press_cnt_q;
  assign edge_count  = edge_cnt_q;

endmodule

// File: tb/tb_key_bounce_gen.sv
// Directed bench for key_bounce_gen with short phase lengths (4/20/20, two bounce pairs).
module tb_key_bounce_gen;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  n_press;
  logic        bounce_en;
  logic        clr_cnt;
  logic        key_n;
  logic        busy;
  logic        done;
  logic [7:0]  press_count;
  logic [15:0] edge_count;

  int unsigned checks = 0;
  int unsigned errors = 0;

  key_bounce_gen #(
    .CNT_W     (8),
    .BOUNCE_CYC(4),
    .HOLD_CYC  (20),
    .GAP_CYC   (20),
    .N_BOUNCE  (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .n_press    (n_press),
    .bounce_en  (bounce_en),
    .clr_cnt    (clr_cnt),
    .key_n      (key_n),
    .busy       (busy),
    .done       (done),
    .press_count(press_count),
    .edge_count (edge_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected key level k cycles after the accepting edge.
  function automatic logic exp_key(input int unsigned k, input logic ben);
    int unsigned p;
    if (!ben) begin
      p = k % 40;
      return (p >= 20);
    end
    p = k % 56;
    if (p < 16) return ((p / 4) % 2) == 1;
    return (p >= 36);
  endfunction

  // Runs one accepted sequence; a stray start with altered inputs is injected at cycle poke.
  task automatic run_seq(input string tag, input logic [3:0] n, input logic ben,
                         input int unsigned len, input int poke);
    int unsigned kerr = 0;
    int unsigned berr = 0;
    n_press = n; bounce_en = ben; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < int'(len); k++) begin
      if (key_n !== exp_key(k, ben)) kerr++;
      if (busy !== 1'b1 || done !== 1'b0) berr++;
      if (k == poke) begin
        start = 1'b1; n_press = 4'd9; bounce_en = ~ben;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    chk({tag, "_wave"}, kerr, 0);
    chk({tag, "_busy"}, berr, 0);
    chk({tag, "_end_busy"}, busy, 0);
    chk({tag, "_end_done"}, done, 1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; n_press = 4'd0; bounce_en = 1'b0; clr_cnt = 1'b0;
    tick(); tick(); tick();
    chk("rst_key", key_n, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pc", press_count, 0);
    chk("rst_ec", edge_count, 0);
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("rel_key", key_n, 1);
    chk("rel_busy", busy, 0);
    chk("rel_ec", edge_count, 0);

    run_seq("clean3", 4'd3, 1'b0, 120, -1);
    chk("clean3_pc", press_count, 3);
    chk("clean3_ec", edge_count, 3);
    tick();
    chk("clean3_done_once", done, 0);

    run_seq("bouncy3", 4'd3, 1'b1, 168, 50);
    chk("bouncy3_pc", press_count, 6);
    chk("bouncy3_ec", edge_count, 12);
    // Start presented in the done cycle, i.e. the first IDLE cycle.
    run_seq("b2b", 4'd1, 1'b0, 40, -1);
    chk("b2b_pc", press_count, 7);
    chk("b2b_ec", edge_count, 13);

    tick();
    n_press = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_key", key_n, 1);
    chk("zero_ec", edge_count, 13);
    tick();
    chk("zero_done_clr", done, 0);

    n_press = 4'd2; bounce_en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    chk("hold10_key", key_n, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_key", key_n, 1);
    chk("arst_busy", busy, 0);
    chk("arst_pc", press_count, 0);
    chk("arst_ec", edge_count, 0);
    tick();
    rst_n = 1'b1;
    tick();
    run_seq("after_rst", 4'd2, 1'b1, 112, -1);
    chk("after_rst_pc", press_count, 2);
    chk("after_rst_ec", edge_count, 6);

    tick();
    n_press = 4'd1; bounce_en = 1'b1; start = 1'b1; clr_cnt = 1'b1;
    tick();
    start = 1'b0; clr_cnt = 1'b0;
    chk("clr_key", key_n, 0);
    chk("clr_ec", edge_count, 0);
    chk("clr_pc", press_count, 0);
    repeat (7) tick();
    chk("clr_c7_ec", edge_count, 0);
    tick();
    chk("clr_c8_key", key_n, 0);
    chk("clr_c8_ec", edge_count, 1);
    repeat (48) tick();
    chk("clr_end_done", done, 1);
    chk("clr_end_ec", edge_count, 2);
    chk("clr_end_pc", press_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_bounce_gen.md
# key_bounce_gen

Synthesizable push-button waveform generator that drives the active-low key line into the debouncer for on-board self-test, in place of a physical button. On each start request it emits a programmable number of presses, either clean or with leading contact bounce, using 50 MHz cycle counts. It also counts the falling edges and complete presses it emitted. The expected counter values for the non-debounced and debounced paths can therefore be compared against these counts on LEDR/HEX.

## Interface
Parameters:
- CNT_W, 24, width of the phase timer; must hold the largest of BOUNCE_CYC, HOLD_CYC, GAP_CYC.
- BOUNCE_CYC, 100_000, length of each bounce glitch half-period (2 ms at 50 MHz).
- HOLD_CYC, 1_250_000, stable-low press time (25 ms).
- GAP_CYC, 1_250_000, stable-high release time after each press (25 ms).
- N_BOUNCE, 2, number of low/high glitch pairs before the stable-low hold; must be at least 1.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- n_press  in  4  presses per request, latched on an accepted start.
- bounce_en  in  1  1 = bouncy presses, 0 = clean presses; latched on an accepted start.
- clr_cnt  in  1  synchronous clear of both counters.
- key_n  out  1  generated key line, active-low, registered; idle 1.
- busy  out  1  high while a sequence is in progress.
- done  out  1  one-cycle pulse at the end of a sequence.
- press_count  out  8  completed presses, wraps at 255 to 0.
- edge_count  out  16  falling edges emitted on key_n, wraps at 65535 to 0.

## Operation
FSM states are IDLE, B_LOW, B_HIGH, HOLD and GAP. A down-counter of CNT_W bits times each phase, and a press counter and a bounce-pair counter sequence the phases.

**IDLE**
- key_n=1, busy=0.
- start=1 with n_press≠0: latch n_press and bounce_en, set busy=1.
  - bounce_en=1: go to B_LOW.
  - bounce_en=0: go to HOLD.
- start=1 with n_press=0: stay in IDLE, pulse done on the next cycle, key_n is untouched.

**Phases**
- B_LOW: key_n=0 for BOUNCE_CYC cycles, then go to B_HIGH.
- B_HIGH: key_n=1 for BOUNCE_CYC cycles.
  - Fewer than N_BOUNCE pairs completed: go to B_LOW.
  - Otherwise: go to HOLD.
- HOLD: key_n=0 for HOLD_CYC cycles, then go to GAP.
- GAP: key_n=1 for GAP_CYC cycles.
  - At the end of GAP, press_count increments by 1.
  - Presses remain: go to B_LOW or HOLD, per the latched bounce_en.
  - Last press: go to IDLE, busy=0, done=1 for one cycle.

**Counters and controls**
- edge_count increments in the same cycle key_n is driven from 1 to 0.
  - Bouncy press: N_BOUNCE+1 edges.
  - Clean press: 1 edge.
- start while busy=1 is ignored; no queuing.
- clr_cnt has priority over any simultaneous increment; that increment is lost.
- Changes to n_press or bounce_en while busy have no effect on the running sequence.

## Timing
**Reset**
- Reset values: key_n=1, busy=0, done=0, press_count=0, edge_count=0, state=IDLE.
- Assertion mid-sequence forces these values immediately, without waiting for a clock edge.

**Start latency**
- start is sampled high at clock edge E0.
- After E0: key_n=0 and busy=1; edge_count increments at E0.
- No other latency is added.

**Phase lengths**
- Each level persists for exactly the programmed cycle count, with no dead cycle between phases.
- Bouncy press: 2·N_BOUNCE·BOUNCE_CYC + HOLD_CYC + GAP_CYC cycles.
- Clean press: HOLD_CYC + GAP_CYC cycles.

**End of sequence**
- busy falls and done rises on the same edge: the edge ending the last GAP cycle.
- press_count shows its final value in that same cycle.
- A start sampled on the first IDLE cycle after done is accepted.

## Test plan
Use CNT_W=8, BOUNCE_CYC=4, HOLD_CYC=20, GAP_CYC=20, N_BOUNCE=2.
- Reset with rst_n=0 -> key_n=1, busy=0, done=0, press_count=0, edge_count=0; release rst_n -> outputs unchanged, no edge.
- start with n_press=3, bounce_en=0 -> key_n pattern low 20 / high 20 three times; busy high for exactly 120 cycles; single done pulse; press_count=3, edge_count=3.
- start with n_press=3, bounce_en=1 -> each press is low 4 / high 4 / low 4 / high 4 / low 20 / high 20 (56 cycles); busy for 168 cycles; edge_count=9, press_count=3.
- start again during a sequence and start with n_press=0 while idle -> the extra start is ignored and the waveform is unchanged; n_press=0 gives a done pulse one cycle after start, with busy=0 and no edge.
- rst_n=0 at cycle 10 of HOLD -> key_n=1 and busy=0 immediately, counters=0; a subsequent start runs a full sequence normally.
- clr_cnt=1 in the same cycle as a B_LOW falling edge -> edge_count=0 after that cycle, the edge is not counted, and later edges count from 1.
